fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch stage between instruction_rom and cpu.
- Drives sequential word addresses into the 1-cycle-latency synchronous instruction ROM and buffers returned words with their PCs in a small FIFO.
- Presents instructions to the cpu through a valid/ready handshake.
- Handles cpu control-flow redirects by flushing buffered and in-flight fetches.

Parameters:
- WIDTH, 32, data/address width.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ROM_RD_EN  out  1  fetch request to ROM this cycle.
- ROM_ADDR  out  WIDTH  fetch byte address.
- ROM_DATA  in  WIDTH  ROM word, valid the cycle after ROM_RD_EN.
- INSTR_VALID  out  1  head entry available.
- INSTR  out  WIDTH  head instruction word.
- INSTR_PC  out  WIDTH  PC of head instruction.
- INSTR_READY  in  1  cpu consumes head when INSTR_VALID=1.
- REDIRECT  in  1  cpu branch/jump taken; flush.
- REDIRECT_PC  in  WIDTH  new fetch address; bits [1:0] forced to 0.

Behaviour:
- Reset (RESET=0, asynchronous):
  - FIFO empty; in-flight flag 0; fetch_pc=RESET_PC; run flag 0.
  - Outputs: ROM_RD_EN=0, ROM_ADDR=RESET_PC, INSTR_VALID=0, INSTR=0, INSTR_PC=0.
  - Mid-operation reset discards all state immediately.
- Startup: run flag sets on the first rising edge with RESET=1. ROM_RD_EN may assert from the following cycle.
- Issue (combinational from registered state): ROM_RD_EN = run && !REDIRECT && (count + inflight < DEPTH). ROM_ADDR = fetch_pc.
- On an issuing edge: fetch_pc += PC_STEP (mod 2^WIDTH, wraps silently); inflight_pc <= fetch_pc; inflight <= 1.
- Return: in the cycle after an issue, ROM_DATA with inflight_pc is pushed at that cycle's end edge.
- Latency: request in cycle n produces INSTR_VALID=1 in cycle n+2. Steady-state throughput is 1 instr/cycle while INSTR_READY=1.
- Credit rule: count + inflight ≤ DEPTH at all times. A push can never overflow, so no ROM backpressure is needed.
- Pop: on an edge with INSTR_VALID && INSTR_READY, the head advances.
  - Simultaneous push and pop: count unchanged.
  - Push into empty FIFO with READY=1: the entry is still presented for ≥1 cycle (no bypass).
- INSTR/INSTR_PC are undefined-but-stable when INSTR_VALID=0. Implementation holds the last head value; the bench must not check them when invalid.
- Redirect (REDIRECT=1 in cycle r):
  - In r: ROM_RD_EN=0.
  - At end of r: FIFO emptied, any push from the ROM return in r dropped, inflight cleared, fetch_pc <= {REDIRECT_PC[WIDTH-1:2],2'b00}.
  - A pop handshake in r is treated as consumed, but the flush supersedes it.
  - INSTR_VALID=0 in r+1; request for REDIRECT_PC issued in r+1; INSTR_VALID=1 in r+3.
  - Back-to-back redirects: the last one wins.
  - REDIRECT before run is set: fetch_pc updated, no issue until run.
- FIFO: separate read/write pointers of log2(DEPTH) bits with wrap-around, plus an occupancy counter of log2(DEPTH)+1 bits. Full = count==DEPTH; empty = count==0.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- Defined: adds output ports FETCH_CNT (32) and FLUSH_CNT (32).
  - FETCH_CNT increments on every edge with ROM_RD_EN=1.
  - FLUSH_CNT increments on every edge with REDIRECT=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset/startup: hold RESET=0 for 10 cycles, release, INSTR_READY=1, ROM word = address → ROM_RD_EN=0 during reset; first INSTR_VALID with INSTR_PC=0x0 three cycles after release; then PCs 0x4, 0x8, 0xC on consecutive cycles.
- Backpressure: INSTR_READY=0 for 20 cycles → exactly DEPTH=4 issues (0x0–0xC), then ROM_RD_EN stays 0. Raising READY pops 0x0, 0x4, 0x8, 0xC in order, and issue resumes at 0x10.
- Redirect: while streaming, pulse REDIRECT with REDIRECT_PC=0x103 at cycle r → INSTR_VALID=0 at r+1; ROM_ADDR=0x100 at r+1; INSTR_PC=0x100 valid at r+3; no pre-redirect PC ever appears afterward.
- Redirect with full FIFO and READY=0, then double redirect (0x40 then 0x80 on consecutive cycles) → queue empties; first delivered PC is 0x80.
- Wrap and reset mid-operation: REDIRECT_PC=0xFFFFFFFC → PCs 0xFFFFFFFC then 0x0. Asserting RESET mid-stream with 3 entries buffered → INSTR_VALID drops asynchronously; after release the stream restarts at RESET_PC.
- With FETCH_QUEUE_PERF_EN: 10 issues and 2 redirects → FETCH_CNT=10, FLUSH_CNT=2; both read 0 after reset.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between a 1-cycle synchronous ROM and the cpu.
// Optional FETCH_QUEUE_PERF_EN adds FETCH_CNT/FLUSH_CNT performance counters.
module fetch_queue #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned      PC_STEP  = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   output logic             ROM_RD_EN,
   output logic [WIDTH-1:0] ROM_ADDR,
   input  logic [WIDTH-1:0] ROM_DATA,
   output logic             INSTR_VALID,
   output logic [WIDTH-1:0] INSTR,
   output logic [WIDTH-1:0] INSTR_PC,
   input  logic             INSTR_READY,
   input  logic             REDIRECT,
   input  logic [WIDTH-1:0] REDIRECT_PC
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0]      FETCH_CNT,
   output logic [31:0]      FLUSH_CNT
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic             r_run;
   logic [WIDTH-1:0] r_fetch_pc;
   logic             r_inflight;
   logic [WIDTH-1:0] r_inflight_pc;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_mem_data [DEPTH];
   logic [WIDTH-1:0] r_mem_pc   [DEPTH];

   logic [CW-1:0]    w_occ;
   logic             w_issue;
   logic             w_push;
   logic             w_pop;

   // Occupancy includes the in-flight request, so a ROM return always has a free slot.
   always_comb begin
      w_occ   = r_count + {{AW{1'b0}}, r_inflight};
      w_issue = r_run && !REDIRECT && (w_occ < CW'(DEPTH));
      w_push  = r_inflight && !REDIRECT;
      w_pop   = (r_count != '0) && INSTR_READY;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_run         <= 1'b0;
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_pc[i]   <= '0;
         end
      end else begin
         r_run <= 1'b1;
         if (REDIRECT) begin
            r_fetch_pc <= {REDIRECT_PC[WIDTH-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
         end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
               r_fetch_pc    <= r_fetch_pc + WIDTH'(PC_STEP);
               r_inflight_pc <= r_fetch_pc;
            end
            if (w_push) begin
               r_mem_data[r_wptr] <= ROM_DATA;
               r_mem_pc[r_wptr]   <= r_inflight_pc;
               r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop) begin
               r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
               r_count <= r_count - 1'b1;
            end
         end
      end
   end

   always_comb begin
      ROM_RD_EN   = w_issue;
      ROM_ADDR    = r_fetch_pc;
      INSTR_VALID = (r_count != '0);
      INSTR       = r_mem_data[r_rptr];
      INSTR_PC    = r_mem_pc[r_rptr];
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_fetch_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_issue) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (REDIRECT) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
      end
   end

   assign FETCH_CNT = r_fetch_cnt;
   assign FLUSH_CNT = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue; ROM model returns the word address as data.
module tb_fetch_queue;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        ROM_RD_EN;
   logic [31:0] ROM_ADDR;
   logic [31:0] rom_data = '0;
   logic        INSTR_VALID;
   logic [31:0] INSTR;
   logic [31:0] INSTR_PC;
   logic        INSTR_READY;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] FETCH_CNT;
   logic [31:0] FLUSH_CNT;
`endif

   int checks = 0;
   int errors = 0;

   fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .ROM_RD_EN   (ROM_RD_EN),
      .ROM_ADDR    (ROM_ADDR),
      .ROM_DATA    (rom_data),
      .INSTR_VALID (INSTR_VALID),
      .INSTR       (INSTR),
      .INSTR_PC    (INSTR_PC),
      .INSTR_READY (INSTR_READY),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC)
`ifdef FETCH_QUEUE_PERF_EN
      ,
      .FETCH_CNT   (FETCH_CNT),
      .FLUSH_CNT   (FLUSH_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (ROM_RD_EN) rom_data <= ROM_ADDR;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b0; INSTR_READY = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = '0;
      for (int i = 0; i < 10; i++) begin
         step(); #1;
         checks++;
         if (ROM_RD_EN !== 1'b0) begin
            errors++; $display("FAIL reset_rd_en cycle %0d: got %b want 0", i, ROM_RD_EN);
         end
      end
      checks++;
      if (ROM_ADDR !== 32'h0 || INSTR_VALID !== 1'b0 || INSTR !== 32'h0 || INSTR_PC !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: addr=%h valid=%b instr=%h pc=%h want 0,0,0,0",
                  ROM_ADDR, INSTR_VALID, INSTR, INSTR_PC);
      end
   endtask

   task automatic test_startup();
      RESET = 1'b1;
      step(); #1;
      checks++;
      if (ROM_RD_EN !== 1'b1 || ROM_ADDR !== 32'h0 || INSTR_VALID !== 1'b0) begin
         errors++; $display("FAIL startup_first_issue: rd=%b addr=%h valid=%b want 1,0,0",
                            ROM_RD_EN, ROM_ADDR, INSTR_VALID);
      end
      step(); #1;
      checks++;
      if (INSTR_VALID !== 1'b0 || ROM_ADDR !== 32'h4) begin
         errors++; $display("FAIL startup_second: valid=%b addr=%h want 0,4", INSTR_VALID, ROM_ADDR);
      end
      for (int k = 0; k < 4; k++) begin
         step(); #1;
         checks++;
         if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'(k*4) || INSTR !== 32'(k*4)) begin
            errors++; $display("FAIL startup_stream %0d: valid=%b pc=%h instr=%h want pc %h",
                               k, INSTR_VALID, INSTR_PC, INSTR, 32'(k*4));
         end
      end
   endtask

   task automatic test_backpressure();
      int issues;
      RESET = 1'b0; INSTR_READY = 1'b0;
      repeat (2) step();
      RESET = 1'b1;
      issues = 0;
      for (int i = 0; i < 20; i++) begin
         step(); #1;
         if (ROM_RD_EN === 1'b1) begin
            checks++;
            if (ROM_ADDR !== 32'(issues*4)) begin
               errors++; $display("FAIL bp_issue_addr: got %h want %h", ROM_ADDR, 32'(issues*4));
            end
            issues++;
         end
      end
      checks++;
      if (issues != 4 || ROM_RD_EN !== 1'b0 || INSTR_VALID !== 1'b1) begin
         errors++; $display("FAIL bp_full: issues=%0d rd=%b valid=%b want 4,0,1",
                            issues, ROM_RD_EN, INSTR_VALID);
      end
      for (int k = 0; k < 4; k++) begin
         INSTR_READY = 1'b1;
         #1;
         checks++;
         if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'(k*4) || INSTR !== 32'(k*4)) begin
            errors++; $display("FAIL bp_drain %0d: valid=%b pc=%h want %h", k, INSTR_VALID, INSTR_PC, 32'(k*4));
         end
         if (k == 0) begin
            checks++;
            if (ROM_RD_EN !== 1'b0) begin
               errors++; $display("FAIL bp_still_full: rd=%b want 0", ROM_RD_EN);
            end
         end
         if (k == 1) begin
            checks++;
            if (ROM_RD_EN !== 1'b1 || ROM_ADDR !== 32'h10) begin
               errors++; $display("FAIL bp_resume: rd=%b addr=%h want 1,10", ROM_RD_EN, ROM_ADDR);
            end
         end
         step();
      end
   endtask

   task automatic test_redirect();
      logic [31:0] exp;
      RESET = 1'b0; INSTR_READY = 1'b1; REDIRECT = 1'b0;
      repeat (2) step();
      RESET = 1'b1;
      repeat (3) step();
      exp = 32'h0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (INSTR_VALID !== 1'b1 || INSTR_PC !== exp) begin
            errors++; $display("FAIL redir_pre_stream: valid=%b pc=%h want %h", INSTR_VALID, INSTR_PC, exp);
         end
         exp = exp + 32'h4;
         step();
      end
      REDIRECT = 1'b1; REDIRECT_PC = 32'h103;
      #1;
      checks++;
      if (ROM_RD_EN !== 1'b0) begin
         errors++; $display("FAIL redir_r_rd_en: got %b want 0", ROM_RD_EN);
      end
      step();
      REDIRECT = 1'b0;
      #1;
      checks++;
      if (INSTR_VALID !== 1'b0 || ROM_RD_EN !== 1'b1 || ROM_ADDR !== 32'h100) begin
         errors++; $display("FAIL redir_r1: valid=%b rd=%b addr=%h want 0,1,100",
                            INSTR_VALID, ROM_RD_EN, ROM_ADDR);
      end
      step(); #1;
      checks++;
      if (INSTR_VALID !== 1'b0) begin
         errors++; $display("FAIL redir_r2_valid: got %b want 0", INSTR_VALID);
      end
      exp = 32'h100;
      for (int i = 0; i < 5; i++) begin
         step(); #1;
         checks++;
         if (INSTR_VALID !== 1'b1 || INSTR_PC !== exp || INSTR !== exp) begin
            errors++; $display("FAIL redir_post_stream %0d: valid=%b pc=%h instr=%h want %h",
                               i, INSTR_VALID, INSTR_PC, INSTR, exp);
         end
         exp = exp + 32'h4;
      end
   endtask

   task automatic test_double_redirect();
      RESET = 1'b0; INSTR_READY = 1'b0; REDIRECT = 1'b0;
      repeat (2) step();
      RESET = 1'b1;
      repeat (8) step();
      #1;
      checks++;
      if (INSTR_VALID !== 1'b1 || ROM_RD_EN !== 1'b0 || INSTR_PC !== 32'h0) begin
         errors++; $display("FAIL dbl_full: valid=%b rd=%b pc=%h want 1,0,0", INSTR_VALID, ROM_RD_EN, INSTR_PC);
      end
      REDIRECT = 1'b1; REDIRECT_PC = 32'h40;
      step();
      REDIRECT_PC = 32'h80;
      #1;
      checks++;
      if (INSTR_VALID !== 1'b0 || ROM_RD_EN !== 1'b0) begin
         errors++; $display("FAIL dbl_second: valid=%b rd=%b want 0,0", INSTR_VALID, ROM_RD_EN);
      end
      step();
      REDIRECT = 1'b0; INSTR_READY = 1'b1;
      #1;
      checks++;
      if (INSTR_VALID !== 1'b0 || ROM_RD_EN !== 1'b1 || ROM_ADDR !== 32'h80) begin
         errors++; $display("FAIL dbl_issue: valid=%b rd=%b addr=%h want 0,1,80", INSTR_VALID, ROM_RD_EN, ROM_ADDR);
      end
      step(); step(); #1;
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h80) begin
         errors++; $display("FAIL dbl_first_pc: valid=%b pc=%h want 1,80", INSTR_VALID, INSTR_PC);
      end
      step(); #1;
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h84) begin
         errors++; $display("FAIL dbl_second_pc: valid=%b pc=%h want 1,84", INSTR_VALID, INSTR_PC);
      end
   endtask

   task automatic test_wrap();
      REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC; INSTR_READY = 1'b1;
      step();
      REDIRECT = 1'b0;
      #1;
      checks++;
      if (ROM_ADDR !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_addr0: got %h want fffffffc", ROM_ADDR);
      end
      step(); #1;
      checks++;
      if (ROM_RD_EN !== 1'b1 || ROM_ADDR !== 32'h0) begin
         errors++; $display("FAIL wrap_addr1: rd=%b addr=%h want 1,0", ROM_RD_EN, ROM_ADDR);
      end
      step(); #1;
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'hFFFF_FFFC || INSTR !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_pc0: valid=%b pc=%h want fffffffc", INSTR_VALID, INSTR_PC);
      end
      step(); #1;
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h0 || INSTR !== 32'h0) begin
         errors++; $display("FAIL wrap_pc1: valid=%b pc=%h want 0", INSTR_VALID, INSTR_PC);
      end
   endtask

   task automatic test_reset_mid();
      RESET = 1'b0; INSTR_READY = 1'b0; REDIRECT = 1'b0;
      repeat (2) step();
      RESET = 1'b1;
      repeat (5) step();
      #1;
      checks++;
      if (INSTR_VALID !== 1'b1 || ROM_RD_EN !== 1'b0 || INSTR_PC !== 32'h0) begin
         errors++; $display("FAIL mid_buffered: valid=%b rd=%b pc=%h want 1,0,0", INSTR_VALID, ROM_RD_EN, INSTR_PC);
      end
      RESET = 1'b0;
      #1;
      checks++;
      if (INSTR_VALID !== 1'b0 || ROM_RD_EN !== 1'b0 || ROM_ADDR !== 32'h0 || INSTR_PC !== 32'h0) begin
         errors++; $display("FAIL mid_async: valid=%b rd=%b addr=%h pc=%h want 0,0,0,0",
                            INSTR_VALID, ROM_RD_EN, ROM_ADDR, INSTR_PC);
      end
      repeat (2) step();
      RESET = 1'b1; INSTR_READY = 1'b1;
      step(); #1;
      checks++;
      if (ROM_RD_EN !== 1'b1 || ROM_ADDR !== 32'h0) begin
         errors++; $display("FAIL mid_restart_issue: rd=%b addr=%h want 1,0", ROM_RD_EN, ROM_ADDR);
      end
      step(); step(); #1;
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h0) begin
         errors++; $display("FAIL mid_restart_pc0: valid=%b pc=%h want 1,0", INSTR_VALID, INSTR_PC);
      end
      step(); #1;
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h4) begin
         errors++; $display("FAIL mid_restart_pc1: valid=%b pc=%h want 1,4", INSTR_VALID, INSTR_PC);
      end
   endtask

   task automatic test_redirect_before_run();
      RESET = 1'b0; INSTR_READY = 1'b1; REDIRECT = 1'b0;
      repeat (2) step();
      RESET = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h202;
      #1;
      checks++;
      if (ROM_RD_EN !== 1'b0) begin
         errors++; $display("FAIL prerun_rd_en: got %b want 0", ROM_RD_EN);
      end
      step();
      REDIRECT = 1'b0;
      #1;
      checks++;
      if (ROM_RD_EN !== 1'b1 || ROM_ADDR !== 32'h200) begin
         errors++; $display("FAIL prerun_addr: rd=%b addr=%h want 1,200", ROM_RD_EN, ROM_ADDR);
      end
      step(); step(); #1;
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h200) begin
         errors++; $display("FAIL prerun_pc: valid=%b pc=%h want 1,200", INSTR_VALID, INSTR_PC);
      end
   endtask

`ifdef FETCH_QUEUE_PERF_EN
   task automatic test_perf();
      RESET = 1'b0; INSTR_READY = 1'b1; REDIRECT = 1'b0;
      step(); #1;
      checks++;
      if (FETCH_CNT !== 32'd0 || FLUSH_CNT !== 32'd0) begin
         errors++; $display("FAIL perf_reset: fetch=%0d flush=%0d want 0,0", FETCH_CNT, FLUSH_CNT);
      end
      step();
      RESET = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if (ROM_RD_EN !== 1'b1) begin
            errors++; $display("FAIL perf_issue %0d: rd=%b want 1", i, ROM_RD_EN);
         end
         step();
      end
      REDIRECT = 1'b1; REDIRECT_PC = 32'h300;
      step(); step();
      REDIRECT = 1'b0;
      #1;
      checks++;
      if (FETCH_CNT !== 32'd10 || FLUSH_CNT !== 32'd2) begin
         errors++; $display("FAIL perf_counts: fetch=%0d flush=%0d want 10,2", FETCH_CNT, FLUSH_CNT);
      end
      RESET = 1'b0;
      #1;
      checks++;
      if (FETCH_CNT !== 32'd0 || FLUSH_CNT !== 32'd0) begin
         errors++; $display("FAIL perf_clear: fetch=%0d flush=%0d want 0,0", FETCH_CNT, FLUSH_CNT);
      end
   endtask
`endif

   initial begin
      RESET = 1'b0; INSTR_READY = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
      test_reset();
      test_startup();
      test_backpressure();
      test_redirect();
      test_double_redirect();
      test_wrap();
      test_reset_mid();
      test_redirect_before_run();
`ifdef FETCH_QUEUE_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
